button_sel_conditioner: RTL and testbench

Conditions the five raw Basys3 push-buttons into stable, registered select and enable controls for the 4:1 nibble mux and 1:4 nibble demux stage that follows it. Each button is synchronised, debounced and edge-detected. Press events step a 2-bit mux select and a 2-bit demux select up or down with wrap-around, and toggle a shared enable. This replaces direct button wiring, so the datapath sees clean, glitch-free, one-change-per-press controls.

---
 rtl/btn_pkg.sv | 16 +
 rtl/button_debounce.sv | 62 ++++++
 rtl/button_sel_conditioner.sv | 94 +++++++++
 tb/tb_button_sel_conditioner.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button select conditioner.
//   SEL_W   : width of the mux/demux select registers
//   BTN_*   : bit positions of each button inside the 5-bit press/raw vectors ({C,R,D,U,L})
//   NUM_BTN : number of buttons handled
package btn_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/button_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability-counter debounce and
// registered rising-edge detect.
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   raw        : raw button input, asynchronous to clk
//   level      : debounced button level
//   rise_pulse : one-cycle pulse, registered, the cycle after level rises
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the debounced level;
  // any agreement (a bounce back) restarts it from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/button_sel_conditioner.sv
// Turns the five raw Basys3 buttons into registered mux/demux selects and a shared enable.
//   clk, rst       : system clock, asynchronous active-high reset
//   btnL / btnU    : step mux_sel down / up (mod 4)
//   btnD / btnR    : step demux_sel down / up (mod 4)
//   btnC           : toggle enable
//   mux_sel        : registered select for the mux stage
//   demux_sel      : registered select for the demux stage
//   enable         : registered enable shared by mux and demux (resets to 1)
//   press          : one-cycle press pulses, bit order {C,R,D,U,L}
module button_sel_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btnL,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             btnR,
  input  logic             btnC,
  output logic [SEL_W-1:0] mux_sel,
  output logic [SEL_W-1:0] demux_sel,
  output logic             enable,
  output logic [NUM_BTN-1:0] press
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic               unused_level;

  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] demux_sel_q, demux_sel_d;
  logic             enable_q, enable_d;

  assign raw = {btnC, btnR, btnD, btnU, btnL};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw[i]),
      .level     (level[i]),
      .rise_pulse(rise[i])
    );
  end

  // Debounced levels are only needed for status; steering uses the press pulses.
  assign unused_level = ^level;

  // Opposing presses in the same cycle cancel rather than racing.
  always_comb begin
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    enable_d    = enable_q;

    case ({rise[BTN_U], rise[BTN_L]})
      2'b10:   mux_sel_d = mux_sel_q + SEL_W'(1);
      2'b01:   mux_sel_d = mux_sel_q - SEL_W'(1);
      default: mux_sel_d = mux_sel_q;
    endcase

    case ({rise[BTN_R], rise[BTN_D]})
      2'b10:   demux_sel_d = demux_sel_q + SEL_W'(1);
      2'b01:   demux_sel_d = demux_sel_q - SEL_W'(1);
      default: demux_sel_d = demux_sel_q;
    endcase

    if (rise[BTN_C]) begin
      enable_d = ~enable_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_sel_q   <= '0;
      demux_sel_q <= '0;
      enable_q    <= 1'b1;
    end else begin
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
      enable_q    <= enable_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign demux_sel = demux_sel_q;
  assign enable    = enable_q;
  assign press     = rise;

endmodule

// File: tb/tb_button_sel_conditioner.sv
// Self-checking bench for button_sel_conditioner with DEBOUNCE_CYCLES=4.
// Reference model: a button's debounced level flips once the last N+1 synchronised
// samples all disagree with it; presses follow a level rise by one cycle and
// selects/enable follow a press by one cycle.
module tb_button_sel_conditioner;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnL = 1'b0, btnU = 1'b0, btnD = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [1:0] mux_sel, demux_sel;
  logic       enable;
  logic [4:0] press;
  logic [9:0] dut_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [4:0] hist[$];
  logic [4:0] m_lvl, m_lvl_d, m_press;
  logic [1:0] m_mux, m_demux;
  logic       m_en;

  always #5 clk = ~clk;

  button_sel_conditioner #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnL     (btnL),
    .btnU     (btnU),
    .btnD     (btnD),
    .btnR     (btnR),
    .btnC     (btnC),
    .mux_sel  (mux_sel),
    .demux_sel(demux_sel),
    .enable   (enable),
    .press    (press)
  );

  assign dut_out = {mux_sel, demux_sel, enable, press};

  function automatic logic [9:0] model_out();
    return {m_mux, m_demux, m_en, m_press};
  endfunction

  // Synchronised value seen at edge k is the raw value sampled two edges earlier.
  function automatic logic [4:0] synced_at(int k);
    if (k - 2 < 0) return 5'b0;
    return hist[k-2];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_lvl   = '0;
    m_lvl_d = '0;
    m_press = '0;
    m_mux   = 2'd0;
    m_demux = 2'd0;
    m_en    = 1'b1;
  endtask

  task automatic model_edge(input logic [4:0] r);
    int k;
    logic [4:0] nl, s;
    logic all_differ;
    k = hist.size();
    if (m_press[1] && !m_press[0]) m_mux = m_mux + 2'd1;
    else if (m_press[0] && !m_press[1]) m_mux = m_mux - 2'd1;
    if (m_press[3] && !m_press[2]) m_demux = m_demux + 2'd1;
    else if (m_press[2] && !m_press[3]) m_demux = m_demux - 2'd1;
    if (m_press[4]) m_en = ~m_en;
    m_press = m_lvl & ~m_lvl_d;
    nl = m_lvl;
    for (int b = 0; b < 5; b++) begin
      all_differ = 1'b1;
      for (int j = 0; j <= int'(N); j++) begin
        s = synced_at(k - j);
        if (s[b] == m_lvl[b]) all_differ = 1'b0;
      end
      if (all_differ) nl[b] = ~m_lvl[b];
    end
    m_lvl_d = m_lvl;
    m_lvl   = nl;
    hist.push_back(r);
  endtask

  // Advance one clock; inputs are sampled at the edge, outputs settle by +1.
  task automatic step();
    logic [4:0] r;
    r = {btnC, btnR, btnD, btnU, btnL};
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_out !== 10'b00_00_1_00000) begin
      n_errors++;
      $display("FAIL reset_async: got %b want %b", dut_out, 10'b00_00_1_00000);
    end
    model_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      n_checks++;
      if (dut_out !== 10'b00_00_1_00000) begin
        n_errors++;
        $display("FAIL reset_hold cyc=%0d: got %b want %b", cyc, dut_out, 10'b00_00_1_00000);
      end
    end
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      n_checks++;
      if (dut_out !== 10'b00_00_1_00000) begin
        n_errors++;
        $display("FAIL reset_idle cyc=%0d: got %b want %b", cyc, dut_out, 10'b00_00_1_00000);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    btnU = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      n_checks++;
      if (press[1] !== (cyc == 7)) begin
        n_errors++;
        $display("FAIL clean_press_pulse edge=%0d: got %b want %b", cyc, press[1], cyc == 7);
      end
      n_checks++;
      if (mux_sel !== ((cyc >= 8) ? 2'd1 : 2'd0)) begin
        n_errors++;
        $display("FAIL clean_press_mux edge=%0d: got %0d want %0d", cyc, mux_sel, cyc >= 8);
      end
      n_checks++;
      if (dut_out !== model_out()) begin
        n_errors++;
        $display("FAIL clean_press_model edge=%0d: got %b want %b", cyc, dut_out, model_out());
      end
    end
    btnU = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      n_checks++;
      if (mux_sel !== 2'd1 || press !== 5'b0) begin
        n_errors++;
        $display("FAIL clean_release cyc=%0d: got mux=%0d press=%b want 1 00000",
                 cyc, mux_sel, press);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int cyc = 0; cyc < 28; cyc++) begin
      btnR = (cyc < 16) ? (((cyc / 2) % 2) == 0) : 1'b0;
      step();
      n_checks++;
      if (demux_sel !== 2'd0 || press !== 5'b0) begin
        n_errors++;
        $display("FAIL bounce cyc=%0d: got demux=%0d press=%b want 0 00000",
                 cyc, demux_sel, press);
      end
      n_checks++;
      if (dut_out !== model_out()) begin
        n_errors++;
        $display("FAIL bounce_model cyc=%0d: got %b want %b", cyc, dut_out, model_out());
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    {btnC, btnU, btnL} = 3'b111;
    for (int cyc = 0; cyc < 15; cyc++) begin
      step();
      n_checks++;
      if (press !== ((cyc == 7) ? 5'b10011 : 5'b00000)) begin
        n_errors++;
        $display("FAIL simul_press edge=%0d: got %b want %b", cyc, press,
                 (cyc == 7) ? 5'b10011 : 5'b00000);
      end
      n_checks++;
      if (mux_sel !== 2'd0 || enable !== (cyc < 8)) begin
        n_errors++;
        $display("FAIL simul_sel edge=%0d: got mux=%0d en=%b want 0 %b",
                 cyc, mux_sel, enable, cyc < 8);
      end
    end
    {btnC, btnU, btnL} = 3'b000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      n_checks++;
      if (dut_out !== model_out()) begin
        n_errors++;
        $display("FAIL simul_model cyc=%0d: got %b want %b", cyc, dut_out, model_out());
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] want;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int cyc = 0; cyc < 24; cyc++) begin
        if (p == 0) btnL = (cyc < 12);
        else btnR = (cyc < 12);
        step();
        n_checks++;
        if (dut_out !== model_out()) begin
          n_errors++;
          $display("FAIL wrap_model p=%0d cyc=%0d: got %b want %b",
                   p, cyc, dut_out, model_out());
        end
      end
      n_checks++;
      if (p == 0) begin
        if (mux_sel !== 2'd3) begin
          n_errors++;
          $display("FAIL wrap_mux: got %0d want 3", mux_sel);
        end
      end else begin
        want = 2'(p);
        if (demux_sel !== want) begin
          n_errors++;
          $display("FAIL wrap_demux press=%0d: got %0d want %0d", p, demux_sel, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses;
    pulses = 0;
    btnD = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_out !== 10'b00_00_1_00000) begin
      n_errors++;
      $display("FAIL midreset_async: got %b want %b", dut_out, 10'b00_00_1_00000);
    end
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      if (press[2]) pulses++;
      n_checks++;
      if (press[2] !== (cyc == 7) || demux_sel !== ((cyc >= 8) ? 2'd3 : 2'd0)) begin
        n_errors++;
        $display("FAIL midreset_seq edge=%0d: got press2=%b demux=%0d want %b %0d",
                 cyc, press[2], demux_sel, cyc == 7, (cyc >= 8) ? 3 : 0);
      end
      n_checks++;
      if (dut_out !== model_out()) begin
        n_errors++;
        $display("FAIL midreset_model edge=%0d: got %b want %b", cyc, dut_out, model_out());
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL midreset_pulses: got %0d want 1", pulses);
    end
    btnD = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_random();
    int hold[5];
    logic [4:0] rv;
    rv = '0;
    for (int b = 0; b < 5; b++) hold[b] = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          rv[b]   = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 12));
        end
        hold[b]--;
      end
      {btnC, btnR, btnD, btnU, btnL} = rv;
      step();
      n_checks++;
      if (dut_out !== model_out()) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d: got %b want %b", cyc, dut_out, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_wrap();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
